spi_parity_tx: RTL and testbench
================================

Name: spi_parity_tx

Overview:
- SPI-style frame transmitter for the odd-parity link: serialises one DATA_W-bit word MSB-first, then appends one odd-parity bit.
- Drives active-low chip select cs, serial clock sclk, a one-cycle sample strobe, and mosi.
- Sits on the initiator side, feeding the link's odd-parity receive checker; upstream logic supplies words over a valid/ready handshake.

Parameters:
- DATA_W, 8, payload bits per frame (1..32).
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).
- GAP, 2, clk cycles cs held high between frames (>=1).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- tx_data  in  DATA_W  word to send; captured at handshake only.
- tx_valid  in  1  upstream has a word.
- tx_ready  out  1  high only in IDLE; transfer when tx_valid&&tx_ready.
- cs  out  1  chip select, active low; idle high.
- sclk  out  1  serial clock; idle low.
- sample  out  1  one-cycle strobe on the first clk of each sclk-high half.
- mosi  out  1  serial data; stable for a whole bit period.
- busy  out  1  high in SHIFT, PARITY and GAP.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values (first edge with reset=1): state IDLE, cs=1, sclk=0, sample=0, mosi=0, busy=0, bit counter 0, phase counter 0. tx_ready=1 from that edge on. Handshakes are ignored while reset is high.
- Outputs are registered except tx_ready, which is decoded from state.
- State machine states: IDLE, SHIFT, PARITY, GAP.
- IDLE:
  - On handshake, latch tx_data into shift register and compute par = ~^tx_data (total ones in data+parity odd).
  - Optional error injection applies here (see Optional Feature).
  - Go to SHIFT. Next cycle cs=0, mosi=MSB.
- Bit period (SHIFT and PARITY): 2*CLK_DIV cycles.
  - First CLK_DIV cycles: sclk=0.
  - Next CLK_DIV cycles: sclk=1.
  - sample=1 only on the first sclk=1 cycle.
  - mosi updates only at the start of a bit period.
- SHIFT: after DATA_W bit periods, go to PARITY with mosi=par.
- PARITY: one bit period, then cs=1, sclk=0, mosi=0; go to GAP.
- GAP: GAP cycles with cs=1, tx_ready=0; then IDLE.
- Latency and frame timing:
  - Handshake to cs fall: 1 cycle.
  - cs low for exactly (DATA_W+1)*2*CLK_DIV cycles.
  - Exactly DATA_W+1 sample pulses per frame, all while cs=0.
  - Minimum handshake-to-handshake spacing: (DATA_W+1)*2*CLK_DIV+GAP+1 cycles.
- Boundary conditions:
  - tx_data or tx_valid changing mid-frame has no effect.
  - tx_valid held high continuously yields back-to-back frames separated by exactly GAP cycles of cs high plus the 1-cycle IDLE.
  - Reset mid-frame: on the next edge cs=1, sclk=0, sample=0 with no partial pulse; the frame is discarded and not retransmitted.
  - Reset coincident with tx_valid: no handshake.
  - Counters must not wrap within a frame; the bit counter is sized clog2(DATA_W+1), the phase counter clog2(2*CLK_DIV).

Optional Feature:
- Macro: SPI_PARITY_TX_ERR_INJ_EN.
- Defined:
  - Adds input port inject_err (1 bit), sampled at handshake.
  - When it is 1, the transmitted parity bit is inverted (even parity) for that frame only.
  - Adds output err_frame (1 bit), high for the whole frame.
- Undefined: neither port exists; the parity bit is always ~^data.

Decomposition:
- Package spi_parity_pkg:
  - State encoding constants (IDLE=0, SHIFT=1, PARITY=2, GAP=3).
  - Odd-parity function odd_par(data) = ~^data.
  - Shared by the transmitter and receiver-side models.
- Sub-module spi_sclk_gen: phase counter producing sclk, the sample strobe, and an end-of-bit tick from CLK_DIV; held in reset when idle.
- The FSM, shift register and bit counter stay in the top module.

Test Plan:
- 0xA5, CLK_DIV=4, GAP=2 -> mosi bits 1,0,1,0,0,1,0,1 then parity 1; cs low 72 cycles; 9 sample pulses; tx_ready high again 75 cycles after handshake.
- 0x01 -> parity 0; 0x00 -> parity 1; 0xFF -> parity 1; number of ones over all 9 sampled bits odd in every case.
- tx_valid held high with words 0x3C then 0xC3 -> cs high exactly 3 cycles between frames (GAP+IDLE); tx_data changed mid-frame does not alter the bits sent.
- reset pulsed for 1 cycle during bit 3 of 0x5A -> next cycle cs=1, sclk=0, no further sample pulses; the following handshake of 0x5A restarts from the MSB.
- Loopback of 200 random words into the odd-parity receive checker -> checker reports a correct frame (running parity 0) at every cs rise.
- With SPI_PARITY_TX_ERR_INJ_EN, inject_err=1 on 0xA5 -> parity bit 0, err_frame high 72 cycles; the next frame with inject_err=0 has correct parity.

Source files
------------

// File: rtl/spi_parity_pkg.sv
// spi_parity_pkg: shared state encoding and odd-parity helper
// for the odd-parity link transmitter and receiver-side models.
package spi_parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  localparam int MAX_W = 32;

  // Odd parity: data plus this bit always holds an odd number of ones.
  function automatic logic odd_par(input logic [MAX_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/spi_parity_tx_if.sv
// spi_parity_tx_if: upstream handshake plus serial link signals.
// SPI_PARITY_TX_ERR_INJ_EN adds inject_err / err_frame.
interface spi_parity_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              cs;
  logic              sclk;
  logic              sample;
  logic              mosi;
  logic              busy;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
  logic              inject_err;
  logic              err_frame;

  modport master (
    output tx_data, tx_valid, inject_err,
    input  tx_ready, cs, sclk, sample,
    input  mosi, busy, err_frame
  );

  modport slave (
    input  tx_data, tx_valid, inject_err,
    output tx_ready, cs, sclk, sample,
    output mosi, busy, err_frame
  );
`else
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, cs, sclk, sample,
    input  mosi, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, cs, sclk, sample,
    output mosi, busy
  );
`endif

endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: per-bit phase counter giving registered sclk,
// a sample strobe on the first high clk, and an end-of-bit tick.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic sclk_o,
  output logic sample_o,
  output logic tick_o
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] ph_q, ph_d;
  logic          sclk_q, sclk_d;
  logic          smp_q, smp_d;

  assign tick_o   = en_i && (ph_q == LAST);
  assign sclk_o   = sclk_q;
  assign sample_o = smp_q;

  // Outputs are precomputed from the next phase so they are registered.
  always_comb begin
    ph_d   = '0;
    sclk_d = 1'b0;
    smp_d  = 1'b0;
    if (en_i) begin
      ph_d   = tick_o ? '0 : ph_q + 1'b1;
      sclk_d = (ph_d >= HALF);
      smp_d  = (ph_d == HALF);
    end
  end

  // Phase state; idles at zero whenever not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q   <= '0;
      sclk_q <= 1'b0;
      smp_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      sclk_q <= sclk_d;
      smp_q  <= smp_d;
    end
  end

endmodule

// File: rtl/spi_parity_tx.sv
// spi_parity_tx: MSB-first word then odd-parity bit on an SPI frame.
// SPI_PARITY_TX_ERR_INJ_EN enables per-frame parity inversion.
module spi_parity_tx
  import spi_parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2
) (
  input logic            clk,
  input logic            reset,
  spi_parity_tx_if.slave bus
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              par_q, par_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              run, tick, inj;

`ifdef SPI_PARITY_TX_ERR_INJ_EN
  logic err_q, err_d;
  assign inj           = bus.inject_err;
  assign bus.err_frame = err_q;
`else
  assign inj = 1'b0;
`endif

  assign run          = (state_q == S_SHIFT) ||
                        (state_q == S_PARITY);
  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.cs       = cs_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .reset    (reset),
    .en_i     (run),
    .sclk_o   (bus.sclk),
    .sample_o (bus.sample),
    .tick_o   (tick)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    par_d   = par_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
    err_d   = err_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.tx_valid) begin
          state_d = S_SHIFT;
          sh_d    = bus.tx_data;
          par_d   = odd_par(32'(bus.tx_data)) ^ inj;
          bit_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = bus.tx_data[DATA_W-1];
          busy_d  = 1'b1;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
          err_d   = inj;
`endif
        end
      end
      (state_q == S_SHIFT): begin
        if (tick) begin
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = S_PARITY;
            mosi_d  = par_q;
          end else begin
            bit_d  = bit_q + 1'b1;
            sh_d   = sh_q << 1;
            mosi_d = sh_d[DATA_W-1];
          end
        end
      end
      (state_q == S_PARITY): begin
        if (tick) begin
          state_d = S_GAP;
          gap_d   = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
          err_d   = 1'b0;
`endif
        end
      end
      (state_q == S_GAP): begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; reset drops any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      par_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      par_q   <= par_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_parity_tx.sv
// tb_spi_parity_tx: directed frames for spi_parity_tx
// (DATA_W=8, CLK_DIV=4, GAP=2), optional SPI_PARITY_TX_ERR_INJ_EN.
module tb_spi_parity_tx;

  localparam int DW = 8;
  localparam int CD = 4;
  localparam int GP = 2;
  localparam int BP = 2 * CD;
  localparam int FL = (DW + 1) * BP;
  localparam int RL = FL + GP + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  spi_parity_tx_if #(.DATA_W(DW)) bus ();

  spi_parity_tx #(
    .DATA_W  (DW),
    .CLK_DIV (CD),
    .GAP     (GP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int to);
    int k;
    k = 0;
    while (bus.tx_ready !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    to = (k >= 200) ? 1 : 0;
  endtask

  // One frame: handshake, then watch every cycle until tx_ready.
  task automatic do_frame(
    input  logic [DW-1:0] d,
    input  logic          inj,
    output logic [DW:0]   bits,
    output int            csl,
    output int            ns,
    output int            rlat,
    output int            bad,
    output int            errc
  );
    int   to, ph;
    logic pm;
    bits = '0;
    csl  = 0;
    ns   = 0;
    rlat = -1;
    bad  = 0;
    errc = 0;
    wait_ready(to);
    if (to != 0) bad += 1000;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
    bus.inject_err = inj;
`else
    if (inj) $display("note: injection not built in");
`endif
    step();
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
    bus.inject_err = 1'b0;
`endif
    pm = bus.mosi;
    for (int n = 1; n <= RL + 5; n++) begin
      ph = (n - 1) % BP;
      if (bus.cs === 1'b0) csl++;
      if (bus.sample === 1'b1) begin
        bits = {bits[DW-1:0], bus.mosi};
        ns++;
      end
      if (n <= FL) begin
        if (bus.cs !== 1'b0) bad++;
        if (bus.sclk !== (ph >= CD)) bad++;
        if (bus.sample !== (ph == CD)) bad++;
        if (ph != 0 && bus.mosi !== pm) bad++;
      end else begin
        if (bus.cs !== 1'b1 || bus.sclk !== 1'b0) bad++;
        if (bus.mosi !== 1'b0 || bus.sample !== 1'b0) bad++;
      end
`ifdef SPI_PARITY_TX_ERR_INJ_EN
      if (bus.err_frame === 1'b1) errc++;
`endif
      pm = bus.mosi;
      if (n == 20) bus.tx_valid = 1'b1;
      if (n == 21) bus.tx_valid = 1'b0;
      if (bus.tx_ready === 1'b1) begin
        rlat = n;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    step();
    step();
    n_vec++;
    if (bus.cs !== 1'b1) begin
      n_err++;
      $display("FAIL rst_cs: got %b want 1", bus.cs);
    end
    n_vec++;
    if (bus.sclk !== 1'b0 || bus.sample !== 1'b0) begin
      n_err++;
      $display("FAIL rst_sclk: got %b/%b want 0/0",
               bus.sclk, bus.sample);
    end
    n_vec++;
    if (bus.mosi !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mosi_busy: got %b/%b want 0/0",
               bus.mosi, bus.busy);
    end
    n_vec++;
    if (bus.tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 1", bus.tx_ready);
    end
    bus.tx_valid = 1'b0;
    reset        = 1'b0;
    step();
    n_vec++;
    if (bus.cs !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_hs: cs/busy %b/%b want 1/0",
               bus.cs, bus.busy);
    end
  endtask

  task automatic test_a5();
    logic [DW:0] b;
    int csl, ns, rl, bad, ec;
    do_frame(8'hA5, 1'b0, b, csl, ns, rl, bad, ec);
    n_vec++;
    if (b !== 9'b1010_0101_1) begin
      n_err++;
      $display("FAIL a5_bits: got %b want 101001011", b);
    end
    n_vec++;
    if (csl != 72) begin
      n_err++;
      $display("FAIL a5_cs_low: got %0d want 72", csl);
    end
    n_vec++;
    if (ns != 9) begin
      n_err++;
      $display("FAIL a5_samples: got %0d want 9", ns);
    end
    n_vec++;
    if (rl != 75) begin
      n_err++;
      $display("FAIL a5_ready_lat: got %0d want 75", rl);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL a5_shape: got %0d errors want 0", bad);
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] wd [3];
    logic          pe [3];
    logic [DW:0]   b;
    int csl, ns, rl, bad, ec;
    wd[0] = 8'h01; pe[0] = 1'b0;
    wd[1] = 8'h00; pe[1] = 1'b1;
    wd[2] = 8'hFF; pe[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_frame(wd[i], 1'b0, b, csl, ns, rl, bad, ec);
      n_vec++;
      if (b !== {wd[i], pe[i]}) begin
        n_err++;
        $display("FAIL par_bits %h: got %b want %b",
                 wd[i], b, {wd[i], pe[i]});
      end
      n_vec++;
      if (($countones(b) % 2) != 1 || bad != 0) begin
        n_err++;
        $display("FAIL par_odd %h: ones %0d bad %0d",
                 wd[i], $countones(b), bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DW+1:0] b;
    int hi, rdy, to;
    b   = '0;
    hi  = 0;
    rdy = -1;
    wait_ready(to);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    step();
    for (int n = 1; n <= 2 * RL + 2; n++) begin
      if (bus.sample === 1'b1) b = {b[2*DW:0], bus.mosi};
      if (n <= RL + FL && bus.cs !== 1'b0) hi++;
      if (n == 10) bus.tx_data = 8'hC3;
      if (n == RL + FL) bus.tx_valid = 1'b0;
      if (n > RL && bus.tx_ready === 1'b1) begin
        rdy = n;
        break;
      end
      step();
    end
    n_vec++;
    if (b !== {8'h3C, 1'b1, 8'hC3, 1'b1} || to != 0) begin
      n_err++;
      $display("FAIL b2b_bits: got %b want 001111001110000111",
               b);
    end
    n_vec++;
    if (hi != GP + 1) begin
      n_err++;
      $display("FAIL b2b_cs_high: got %0d want %0d", hi, GP + 1);
    end
    n_vec++;
    if (rdy != 2 * RL) begin
      n_err++;
      $display("FAIL b2b_ready: got %0d want %0d", rdy, 2 * RL);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  pb;
    logic [DW:0] b;
    int ns, ls, lc, to, csl, fns, rl, bad, ec;
    pb = '0;
    ns = 0;
    ls = 0;
    lc = 0;
    wait_ready(to);
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      if (bus.sample === 1'b1) begin
        pb = {pb[1:0], bus.mosi};
        ns++;
      end
      if (n < 27) step();
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (bus.cs !== 1'b1 || bus.sclk !== 1'b0 ||
        bus.sample !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_lines: cs/sclk/smp %b%b%b want 100",
               bus.cs, bus.sclk, bus.sample);
    end
    reset = 1'b0;
    for (int n = 0; n < 80; n++) begin
      step();
      if (bus.sample !== 1'b0) ls++;
      if (bus.cs !== 1'b1) lc++;
    end
    n_vec++;
    if (ls != 0 || lc != 0) begin
      n_err++;
      $display("FAIL rmid_quiet: smp %0d cs_low %0d want 0 0",
               ls, lc);
    end
    n_vec++;
    if (ns != 3 || pb !== 3'b010 || to != 0) begin
      n_err++;
      $display("FAIL rmid_partial: got %0d bits %b want 3 010",
               ns, pb);
    end
    do_frame(8'h5A, 1'b0, b, csl, fns, rl, bad, ec);
    n_vec++;
    if (b !== 9'b0101_1010_1 || bad != 0) begin
      n_err++;
      $display("FAIL rmid_resend: got %b bad %0d want 010110101",
               b, bad);
    end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] w;
    logic [DW:0]   b;
    int csl, ns, rl, bad, ec;
    for (int i = 0; i < 200; i++) begin
      w = DW'($urandom_range(0, 255));
      do_frame(w, 1'b0, b, csl, ns, rl, bad, ec);
      n_vec++;
      if ((^b) !== 1'b1 || ns != 9) begin
        n_err++;
        $display("FAIL loop_par %0d: got %b (%0d bits) want odd",
                 i, b, ns);
      end
      n_vec++;
      if (b !== {w, ~^w} || bad != 0) begin
        n_err++;
        $display("FAIL loop_bits %0d: got %b want %b bad %0d",
                 i, b, {w, ~^w}, bad);
      end
    end
  endtask

`ifdef SPI_PARITY_TX_ERR_INJ_EN
  task automatic test_err_inj();
    logic [DW:0] b;
    int csl, ns, rl, bad, ec;
    do_frame(8'hA5, 1'b1, b, csl, ns, rl, bad, ec);
    n_vec++;
    if (b !== 9'b1010_0101_0) begin
      n_err++;
      $display("FAIL inj_bits: got %b want 101001010", b);
    end
    n_vec++;
    if (ec != 72) begin
      n_err++;
      $display("FAIL inj_err_frame: got %0d want 72", ec);
    end
    do_frame(8'hA5, 1'b0, b, csl, ns, rl, bad, ec);
    n_vec++;
    if (b !== 9'b1010_0101_1 || ec != 0) begin
      n_err++;
      $display("FAIL inj_next: got %b err %0d want 101001011 0",
               b, ec);
    end
  endtask
`endif

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
`ifdef SPI_PARITY_TX_ERR_INJ_EN
    bus.inject_err = 1'b0;
`endif
    test_reset();
    test_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
`ifdef SPI_PARITY_TX_ERR_INJ_EN
    test_err_inj();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
